// File: rtl/kpn_pkg.sv
// Shared constants and mode encodings for the KPN channel layer.
// Imported by every channel FIFO and its storage sub-module.
package kpn_pkg;

  localparam int KPN_DATA_W = 16;
  localparam int KPN_ADDR_W = 5;

  typedef enum logic {
    KPN_STD  = 1'b0,
    KPN_FWFT = 1'b1
  } kpn_mode_e;

endpackage

// File: rtl/kpn_fifo_mem.sv
// 2**W x B storage for one Kahn channel: synchronous write, plus one
// registered read port (standard mode) and one asynchronous read port (FWFT).
module kpn_fifo_mem
  import kpn_pkg::*;
#(
  parameter int B = KPN_DATA_W,
  parameter int W = KPN_ADDR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [W-1:0] waddr,
  input  logic [B-1:0] wdata,
  input  logic         re,
  input  logic [W-1:0] raddr,
  output logic [B-1:0] rdata_q,
  output logic [B-1:0] rdata_async
);

  logic [B-1:0] mem [2**W];

  // NOTE: the array has no reset; clearing it would prevent RAM inference and
  // is unnecessary because count/empty gate every read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata_async = mem[raddr];

endmodule

// File: rtl/kpn_fifo_channel.sv
// Word-wide Kahn channel FIFO: pointers, occupancy count, registered flags,
// sticky error flags and standard / first-word-fall-through read modes.
module kpn_fifo_channel
  import kpn_pkg::*;
#(
  parameter int B        = KPN_DATA_W,
  parameter int W        = KPN_ADDR_W,
  parameter int AF_LEVEL = 2**W - 2,
  parameter int FWFT     = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [B-1:0] entry_1,
  input  logic         rd,
  output logic [B-1:0] output_1,
  output logic         out_valid,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic [W:0]   count,
  input  logic         err_clr,
  output logic         overflow,
  output logic         underflow
);

  localparam bit       USE_FWFT = (FWFT == int'(KPN_FWFT));
  localparam logic [W:0] DEPTH  = (W+1)'(2**W);
  localparam logic [W:0] AF_LVL = (W+1)'(AF_LEVEL);

  logic [W-1:0] w_ptr, r_ptr;
  logic         rd_acc, wr_acc;
  logic [W:0]   count_next;
  logic         std_valid;
  logic [B-1:0] rdata_q, rdata_async;

  // Acceptance looks only at registered flags, so a write into a full FIFO
  // succeeds exactly when a read frees a slot on the same edge.
  assign rd_acc     = rd & ~empty;
  assign wr_acc     = wr & (~full | rd_acc);
  assign count_next = count + (W+1)'(wr_acc) - (W+1)'(rd_acc);

  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr       <= '0;
      r_ptr       <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      std_valid   <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (wr_acc) w_ptr <= w_ptr + W'(1);
      if (rd_acc) r_ptr <= r_ptr + W'(1);
      count       <= count_next;
      empty       <= (count_next == '0);
      full        <= (count_next == DEPTH);
      almost_full <= (count_next >= AF_LVL);
      std_valid   <= rd_acc;
      // A new error event wins over a simultaneous clear.
      overflow    <= (overflow  & ~err_clr) | (wr & ~wr_acc);
      underflow   <= (underflow & ~err_clr) | (rd & ~rd_acc);
    end
  end

  kpn_fifo_mem #(
    .B (B),
    .W (W)
  ) u_mem (
    .clk         (clk),
    .reset       (reset),
    .we          (wr_acc),
    .waddr       (w_ptr),
    .wdata       (entry_1),
    .re          (rd_acc),
    .raddr       (r_ptr),
    .rdata_q     (rdata_q),
    .rdata_async (rdata_async)
  );

  assign output_1  = USE_FWFT ? rdata_async : rdata_q;
  assign out_valid = USE_FWFT ? ~empty      : std_valid;

endmodule

// File: tb/tb_kpn_fifo_channel.sv
// Directed bench for kpn_fifo_channel: one standard-mode and one FWFT-mode
// instance (B=16, W=2, AF_LEVEL=3) driven through a linear step sequence.
module tb_kpn_fifo_channel;

  localparam int B = 16;
  localparam int W = 2;

  logic clk = 1'b0;
  logic reset;

  logic         s_wr, s_rd, s_err_clr;
  logic [B-1:0] s_entry;
  logic [B-1:0] s_out;
  logic         s_valid, s_full, s_empty, s_af, s_ovf, s_udf;
  logic [W:0]   s_count;

  logic         f_wr, f_rd, f_err_clr;
  logic [B-1:0] f_entry;
  logic [B-1:0] f_out;
  logic         f_valid, f_full, f_empty, f_af, f_ovf, f_udf;
  logic [W:0]   f_count;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  kpn_fifo_channel #(.B(B), .W(W), .AF_LEVEL(3), .FWFT(0)) dut_std (
    .clk(clk), .reset(reset), .wr(s_wr), .entry_1(s_entry), .rd(s_rd),
    .output_1(s_out), .out_valid(s_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .count(s_count), .err_clr(s_err_clr),
    .overflow(s_ovf), .underflow(s_udf)
  );

  kpn_fifo_channel #(.B(B), .W(W), .AF_LEVEL(3), .FWFT(1)) dut_fwft (
    .clk(clk), .reset(reset), .wr(f_wr), .entry_1(f_entry), .rd(f_rd),
    .output_1(f_out), .out_valid(f_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .count(f_count), .err_clr(f_err_clr),
    .overflow(f_ovf), .underflow(f_udf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle outputs before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    s_wr = 0; s_rd = 0; s_err_clr = 0; s_entry = '0;
    f_wr = 0; f_rd = 0; f_err_clr = 0; f_entry = '0;
    tick();
    tick();
    check("rst_count", 32'(s_count), 0);
    check("rst_empty", 32'(s_empty), 1);
    check("rst_full", 32'(s_full), 0);
    check("rst_af", 32'(s_af), 0);
    check("rst_valid", 32'(s_valid), 0);
    check("rst_out", 32'(s_out), 0);
    check("rst_ovf", 32'(s_ovf), 0);
    check("rst_udf", 32'(s_udf), 0);
    check("rst_fwft_valid", 32'(f_valid), 0);
    reset = 1'b0;

    // Standard mode: two writes then two reads.
    s_wr = 1; s_entry = 16'h0011; tick();
    s_entry = 16'h0022; tick();
    s_wr = 0;
    check("t1_count2", 32'(s_count), 2);
    check("t1_not_empty", 32'(s_empty), 0);
    s_rd = 1; tick();
    check("t1_rd1_out", 32'(s_out), 32'h0011);
    check("t1_rd1_valid", 32'(s_valid), 1);
    tick();
    check("t1_rd2_out", 32'(s_out), 32'h0022);
    check("t1_rd2_valid", 32'(s_valid), 1);
    check("t1_empty", 32'(s_empty), 1);
    s_rd = 0; tick();
    check("t1_valid_pulse_end", 32'(s_valid), 0);
    check("t1_out_hold", 32'(s_out), 32'h0022);

    // Fill to full, then one refused write.
    s_wr = 1;
    for (int i = 0; i < 4; i++) begin
      s_entry = 16'hA000 + 16'(i);
      tick();
      if (i == 1) check("t2_af_below", 32'(s_af), 0);
      if (i == 2) check("t2_af_at3", 32'(s_af), 1);
    end
    check("t2_full", 32'(s_full), 1);
    check("t2_count4", 32'(s_count), 4);
    s_entry = 16'hDEAD; tick();
    check("t2_overflow", 32'(s_ovf), 1);
    check("t2_count_kept", 32'(s_count), 4);

    // Full with simultaneous write and read.
    s_rd = 1; s_entry = 16'hBEEF; tick();
    s_wr = 0;
    check("t3_head", 32'(s_out), 32'hA000);
    check("t3_count", 32'(s_count), 4);
    check("t3_full", 32'(s_full), 1);
    tick(); check("t3_drain1", 32'(s_out), 32'hA001);
    check("t3_not_full", 32'(s_full), 0);
    tick(); check("t3_drain2", 32'(s_out), 32'hA002);
    tick(); check("t3_drain3", 32'(s_out), 32'hA003);
    tick(); check("t3_drain_beef", 32'(s_out), 32'hBEEF);
    check("t3_empty", 32'(s_empty), 1);
    check("t3_ovf_sticky", 32'(s_ovf), 1);
    check("t3_udf_clean", 32'(s_udf), 0);

    // Empty: refused read, then write+read together, then clear.
    tick();
    s_rd = 0;
    check("t4_underflow", 32'(s_udf), 1);
    check("t4_valid0", 32'(s_valid), 0);
    check("t4_out_hold", 32'(s_out), 32'hBEEF);
    s_wr = 1; s_rd = 1; s_entry = 16'h1234; tick();
    s_wr = 0; s_rd = 0;
    check("t4_count1", 32'(s_count), 1);
    check("t4_udf_still", 32'(s_udf), 1);
    check("t4_no_bypass", 32'(s_valid), 0);
    s_err_clr = 1; tick();
    s_err_clr = 0;
    check("t4_ovf_clr", 32'(s_ovf), 0);
    check("t4_udf_clr", 32'(s_udf), 0);
    s_rd = 1; tick();
    s_rd = 0;
    check("t4_read_1234", 32'(s_out), 32'h1234);
    check("t4_empty_again", 32'(s_empty), 1);

    // FWFT: head visible with no read request.
    f_wr = 1; f_entry = 16'h0055; tick();
    f_wr = 0;
    check("t5_valid", 32'(f_valid), 1);
    check("t5_out", 32'(f_out), 32'h0055);
    tick();
    check("t5_valid_hold", 32'(f_valid), 1);
    f_rd = 1; tick();
    f_rd = 0;
    check("t5_pop_valid0", 32'(f_valid), 0);
    f_wr = 1; f_entry = 16'h0066; tick();
    f_entry = 16'h0077; tick();
    f_wr = 0;
    check("t5_head66", 32'(f_out), 32'h0066);
    f_rd = 1; tick();
    f_rd = 0;
    check("t5_head77", 32'(f_out), 32'h0077);
    check("t5_count1", 32'(f_count), 1);

    // Pointer wrap with interleaved write/read pairs.
    for (int i = 0; i < 10; i++) begin
      s_wr = 1; s_entry = 16'h5000 + 16'(i); tick();
      s_wr = 0; s_rd = 1; tick();
      s_rd = 0;
      check($sformatf("t6_wrap%0d", i), 32'(s_out), 32'h5000 + i);
    end

    // Reset mid-operation with count=3 and an error pending.
    s_rd = 1; tick();
    s_rd = 0;
    check("t6_udf_pre", 32'(s_udf), 1);
    s_wr = 1;
    for (int i = 0; i < 3; i++) begin
      s_entry = 16'h6000 + 16'(i); tick();
    end
    s_wr = 0;
    check("t6_count3", 32'(s_count), 3);
    reset = 1; tick();
    reset = 0;
    check("t6_rst_count", 32'(s_count), 0);
    check("t6_rst_empty", 32'(s_empty), 1);
    check("t6_rst_valid", 32'(s_valid), 0);
    check("t6_rst_udf", 32'(s_udf), 0);
    check("t6_rst_af", 32'(s_af), 0);
    s_wr = 1; s_entry = 16'h7777; tick();
    s_wr = 0; s_rd = 1; tick();
    s_rd = 0;
    check("t6_readback", 32'(s_out), 32'h7777);
    check("t6_readback_valid", 32'(s_valid), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
